// File: rtl/i2c_config_sequencer.sv
// i2c_config_sequencer
//   Feeds a brute-force 4-byte I2C writer from a small table of configuration words.
//   The writer has no busy or ack output, so each entry is paced by fixed timing:
//     SETUP  (1 cycle)       : present the entry's lines/data; enable stays low.
//     PULSE  (ENABLE_HOLD)   : enable high, long enough for the writer's slow clock to see it.
//     GAP    (TX_WAIT)       : enable low, data held while the frame shifts out.
//   After the last entry, a one-cycle FINISH raises DONE.
//
// Ports
//   CLK, RESET          : single clock; synchronous active-high reset.
//   WR_EN/WR_ADDR/WR_DATA : table write port {lines[1:0], data12[15:0], data34[15:0]}.
//                         Ignored while BUSY.
//   NUM_ENTRIES         : entries to send. Sampled on START and clamped to DEPTH.
//   START / ABORT       : start a sequence (sampled in IDLE) / stop after the current entry.
//   BUSY, DONE          : sequence in progress / one-cycle pulse on normal completion.
//   CUR_INDEX           : entry currently presented.
//   I2C_ENABLE, I2C_LINES, I2C_DATA12, I2C_DATA34 : to the writer.
module i2c_config_sequencer #(
  parameter int DEPTH       = 8,
  parameter int ENABLE_HOLD = 131072,
  parameter int TX_WAIT     = 6291456,
  parameter int CNT_W       = 24,
  localparam int IW         = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          WR_EN,
  input  logic [IW-1:0] WR_ADDR,
  input  logic [33:0]   WR_DATA,
  input  logic [IW:0]   NUM_ENTRIES,
  input  logic          START,
  input  logic          ABORT,
  output logic          BUSY,
  output logic          DONE,
  output logic [IW-1:0] CUR_INDEX,
  output logic          I2C_ENABLE,
  output logic [1:0]    I2C_LINES,
  output logic [15:0]   I2C_DATA12,
  output logic [15:0]   I2C_DATA34
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_GAP,
    S_FINISH
  } state_e;

  // The counter is loaded with N-1 on state entry, so a state lasts N cycles.
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(ENABLE_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(TX_WAIT - 1);
  localparam logic [IW:0]      DEPTH_N   = (IW+1)'(DEPTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW:0]      num_q, num_d;
  logic             abort_q, abort_d;
  logic [33:0]      table_q [DEPTH];

  logic             busy;
  logic [IW:0]      num_clamped;
  logic [IW:0]      idx_plus_one;
  logic [33:0]      cur_word;

  assign busy         = (state_q == S_SETUP) || (state_q == S_PULSE) || (state_q == S_GAP);
  assign num_clamped  = (NUM_ENTRIES > DEPTH_N) ? DEPTH_N : NUM_ENTRIES;
  assign idx_plus_one = {1'b0, idx_q} + {{IW{1'b0}}, 1'b1};
  assign cur_word     = table_q[idx_q];

  // NOTE: every variable written here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    num_d   = num_q;
    abort_d = abort_q;

    // ABORT is only remembered during a sequence; IDLE clears it below.
    if (busy && ABORT) abort_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (START) begin
          num_d   = num_clamped;
          idx_d   = '0;
          state_d = (num_clamped == '0) ? S_FINISH : S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d   = HOLD_LOAD;
        state_d = S_PULSE;
      end
      S_PULSE: begin
        if (cnt_q == '0) begin
          cnt_d   = GAP_LOAD;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          // The writer frame cannot be cancelled, so abort is honoured only here.
          if (abort_q || ABORT) begin
            state_d = S_IDLE;
          end else if (idx_plus_one == num_q) begin
            state_d = S_FINISH;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_SETUP;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      num_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
      abort_q <= abort_d;
    end
  end

  // NOTE: the table is reset to zero on purpose, so a sequence started before any write sends released buses.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
    end else if (WR_EN && !busy) begin
      table_q[WR_ADDR] <= WR_DATA;
    end
  end

  // The table cannot change while busy, so a direct read keeps the data stable through each entry.
  // Outside a sequence both buses are released (lines 00) and data reads as zero.
  assign BUSY       = busy;
  assign DONE       = (state_q == S_FINISH);
  assign CUR_INDEX  = idx_q;
  assign I2C_ENABLE = (state_q == S_PULSE) && !RESET;
  assign I2C_LINES  = busy ? cur_word[33:32] : 2'b00;
  assign I2C_DATA12 = busy ? cur_word[31:16] : 16'h0000;
  assign I2C_DATA34 = busy ? cur_word[15:0]  : 16'h0000;

endmodule
